// File: rtl/dbg_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_trace_pkg
// Description : Shared types for the debug trace controller: controller state
//               encoding, MODE input encodings, the trace-entry view struct and
//               a byte-pick helper used by the LED mux.
// Build macro : none here (DBG_TRACE_WRAP_EN is consumed by dbg_trace_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_trace_pkg;

    // Widest data word the LED view can address (four byte lanes).
    localparam int c_trace_max_w = 32;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_STEP1 = 2'd1,
        ST_RUNN  = 2'd2,
        ST_FREE  = 2'd3
    } dbg_state_t;

    localparam logic [1:0] c_mode_halt  = 2'b00;
    localparam logic [1:0] c_mode_step  = 2'b01;
    localparam logic [1:0] c_mode_run_n = 2'b10;
    localparam logic [1:0] c_mode_free  = 2'b11;

    // One trace entry, fields normalised to c_trace_max_w so that byte lanes
    // beyond a narrow DATA_W read as zero.
    typedef struct packed {
        logic [c_trace_max_w-1:0] inst;
        logic [c_trace_max_w-1:0] res;
        logic                     we;
    } trace_entry_t;

    function automatic logic [7:0] view_byte(input logic [c_trace_max_w-1:0] word,
                                             input logic [1:0]               idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : dbg_trace_ram
// Description : Trace storage, DEPTH x WIDTH register array with a single
//               synchronous write port and an asynchronous read port.
// Ports       : clk        - write clock
//               we         - write enable
//               waddr/wdata- write address / data
//               raddr      - read address
//               rdata      - read data (combinational from raddr)
// Build macro : none
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_trace_ram
    import dbg_trace_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the
    // controller's occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dbg_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbg_trace_ctrl
// Description : Debug single-step / run-N / free-run controller for a soft
//               core, with a FWFT trace ring capturing {inst, res, we} on every
//               enabled core cycle and a registered LED byte view of the head.
// Ports       : clk, rst            - clock, async active-high reset
//               mode, step, run_cnt - run control (HALT/STEP/RUN_N/FREE)
//               cpu_en              - core clock enable
//               tr_inst/tr_res/tr_we- core debug taps
//               rd_req              - pop head entry
//               rd_valid/rd_inst/rd_res/rd_we - head entry (fall-through)
//               sel, led            - LED byte select / registered byte
//               count, full, overflow - occupancy and status
// Build macro : DBG_TRACE_WRAP_EN - defined: overwrite oldest entry when full
//               and flag overflow; undefined: stall the core while full.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_trace_ctrl
    import dbg_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     step,
    input  logic [CNT_W-1:0]         run_cnt,
    output logic                     cpu_en,
    input  logic [DATA_W-1:0]        tr_inst,
    input  logic [DATA_W-1:0]        tr_res,
    input  logic                     tr_we,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_inst,
    output logic [DATA_W-1:0]        rd_res,
    output logic                     rd_we,
    input  logic [2:0]               sel,
    output logic [7:0]               led,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_ew = 2 * DATA_W + 1;

    localparam logic [c_aw-1:0]  c_ptr_one    = (c_aw)'(1);
    localparam logic [c_aw:0]    c_count_one  = (c_aw + 1)'(1);
    localparam logic [c_aw:0]    c_full_count = (c_aw + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one    = (CNT_W)'(1);

    dbg_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              r_full;
    logic [7:0]        r_led;

    logic              w_cpu_en;
    logic              w_push;
    logic              w_pop;
    logic [c_aw:0]     w_count_nxt;
    logic [c_ew-1:0]   w_head;
    trace_entry_t      w_view;
    logic [7:0]        w_led_nxt;

    // ------------------------------------------------------------------------
    // Core enable: any non-HALT state runs the core. Without wrap, a full ring
    // (registered) holds the core off so no trace is lost.
    // ------------------------------------------------------------------------
`ifdef DBG_TRACE_WRAP_EN
    assign w_cpu_en = (r_state != ST_HALT);
`else
    assign w_cpu_en = (r_state != ST_HALT) && !r_full;
`endif

    assign w_push = w_cpu_en;
    assign w_pop  = rd_req && (r_count != '0);

    // ------------------------------------------------------------------------
    // Run-control FSM. MODE is only looked at in HALT and FREE so a mode
    // change cannot truncate a step or a run. STEP1 and RUNN only make
    // progress on cycles where the core is actually enabled.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HALT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (mode == c_mode_free) begin
                        r_state <= ST_FREE;
                    end else if (step && (mode == c_mode_step)) begin
                        r_state <= ST_STEP1;
                    end else if (step && (mode == c_mode_run_n) && (run_cnt != '0)) begin
                        r_state <= ST_RUNN;
                        r_cnt   <= run_cnt;
                    end
                end
                ST_STEP1: begin
                    if (w_cpu_en) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_RUNN: begin
                    if (w_cpu_en) begin
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= ST_HALT;
                        end
                    end
                end
                ST_FREE: begin
                    if (mode != c_mode_free) begin
                        r_state <= ST_HALT;
                    end
                end
                default: r_state <= ST_HALT;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Ring pointers and occupancy. A push into a full ring (wrap build only)
    // overwrites the head, so the read pointer advances once whether that
    // happens alone or together with a pop.
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop && !r_full) begin
            w_count_nxt = r_count + c_count_one;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_count_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop || (w_push && r_full)) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_count);
        end
    end

`ifdef DBG_TRACE_WRAP_EN
    logic r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && r_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    dbg_trace_ram #(
        .WIDTH (c_ew),
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata ({tr_inst, tr_res, tr_we}),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // ------------------------------------------------------------------------
    // Head view and LED byte mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_view.inst = (c_trace_max_w)'(w_head[c_ew-1 -: DATA_W]);
        w_view.res  = (c_trace_max_w)'(w_head[DATA_W:1]);
        w_view.we   = w_head[0];
    end

    assign w_led_nxt = sel[2] ? view_byte(w_view.res,  sel[1:0])
                              : view_byte(w_view.inst, sel[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= (r_count != '0) ? w_led_nxt : 8'h00;
        end
    end

    assign cpu_en   = w_cpu_en;
    assign rd_valid = (r_count != '0);
    assign rd_inst  = w_head[c_ew-1 -: DATA_W];
    assign rd_res   = w_head[DATA_W:1];
    assign rd_we    = w_view.we;
    assign led      = r_led;
    assign count    = r_count;
    assign full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_dbg_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_trace_ctrl
// Description : Directed self-checking bench for dbg_trace_ctrl (DEPTH=16).
//               Inputs change and outputs are sampled on the falling edge.
//               Build with or without DBG_TRACE_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_trace_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        step;
    logic [7:0]  run_cnt;
    logic        cpu_en;
    logic [31:0] tr_inst;
    logic [31:0] tr_res;
    logic        tr_we;
    logic        rd_req;
    logic        rd_valid;
    logic [31:0] rd_inst;
    logic [31:0] rd_res;
    logic        rd_we;
    logic [2:0]  sel;
    logic [7:0]  led;
    logic [4:0]  count;
    logic        full;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int en_seen = 0;

    always #5 clk = ~clk;

    dbg_trace_ctrl #(
        .DATA_W (32),
        .DEPTH  (16),
        .CNT_W  (8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .step     (step),
        .run_cnt  (run_cnt),
        .cpu_en   (cpu_en),
        .tr_inst  (tr_inst),
        .tr_res   (tr_res),
        .tr_we    (tr_we),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_inst  (rd_inst),
        .rd_res   (rd_res),
        .rd_we    (rd_we),
        .sel      (sel),
        .led      (led),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and tally enabled core cycles.
    task automatic tick();
        @(negedge clk);
        if (cpu_en === 1'b1) en_seen++;
    endtask

    task automatic pop_one();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        logic [5:0] pat;
        logic [2:0] sel_tab [5];
        logic [7:0] led_tab [5];

        rst = 1'b1; mode = 2'b00; step = 1'b0; run_cnt = 8'd0;
        tr_inst = '0; tr_res = '0; tr_we = 1'b0; rd_req = 1'b0; sel = 3'd0;
        pat = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_cpu_en",   {63'd0, cpu_en},   64'd0);
        chk("rst_count",    {59'd0, count},    64'd0);
        chk("rst_full",     {63'd0, full},     64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_led",      {56'd0, led},      64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        rst = 1'b0;
        tick();

        // ---------------- STEP x4 ----------------
        e0 = en_seen;
        mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tr_inst = 32'h2008_0005 + k;
            tr_res  = 32'h0000_1000 + k;
            tr_we   = k[0];
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
            tick();
        end
        chk("step_en_cycles", 64'(en_seen - e0), 64'd4);
        chk("step_count",     {59'd0, count},    64'd4);
        chk("step_head_inst", {32'd0, rd_inst},  64'h2008_0005);
        chk("step_head_res",  {32'd0, rd_res},   64'h1000);
        chk("step_head_we",   {63'd0, rd_we},    64'd0);
        pop_one();
        chk("step_pop_inst",  {32'd0, rd_inst},  64'h2008_0006);
        chk("step_pop_we",    {63'd0, rd_we},    64'd1);
        chk("step_pop_count", {59'd0, count},    64'd3);
        pop_one(); pop_one(); pop_one();
        chk("step_drain_valid", {63'd0, rd_valid}, 64'd0);
        pop_one();
        chk("empty_pop_count", {59'd0, count}, 64'd0);

        // ---------------- RUN_N = 5, MODE flipped to FREE mid-run ----------------
        mode = 2'b10; run_cnt = 8'd5; step = 1'b1;
        tick();
        step = 1'b0;
        for (int s = 0; s < 6; s++) begin
            pat = {pat[4:0], cpu_en};
            tr_inst = 32'h300 + s;
            if (s == 1) mode = 2'b11;
            if (s == 5) mode = 2'b00;
            tick();
        end
        chk("runn_pattern",   {58'd0, pat},     64'b111110);
        chk("runn_halted",    {63'd0, cpu_en},  64'd0);
        chk("runn_count",     {59'd0, count},   64'd5);
        chk("runn_head_inst", {32'd0, rd_inst}, 64'h300);
        for (int i = 0; i < 5; i++) pop_one();
        chk("runn_drain_valid", {63'd0, rd_valid}, 64'd0);

        // ---------------- LED byte view ----------------
        mode = 2'b01; tr_inst = 32'h1122_3344; tr_res = 32'hDEAD_BEEF; tr_we = 1'b1;
        sel = 3'd0; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        chk("led_inst_b0", {56'd0, led}, 64'h44);
        sel = 3'd4;
        #1;
        chk("led_hold_before_edge", {56'd0, led}, 64'h44);
        sel_tab = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
        led_tab = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11};
        for (int i = 0; i < 5; i++) begin
            sel = sel_tab[i];
            tick();
            chk($sformatf("led_sel%0d", sel_tab[i]), {56'd0, led}, {56'd0, led_tab[i]});
        end
        pop_one();
        tick();
        chk("led_empty", {56'd0, led}, 64'd0);
        chk("led_empty_valid", {63'd0, rd_valid}, 64'd0);

        // ---------------- async reset mid-RUNN ----------------
        mode = 2'b10; run_cnt = 8'd8; tr_inst = 32'h77; tr_res = 32'h55; sel = 3'd4;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_count",  {59'd0, count},  64'd3);
        chk("pre_rst_cpu_en", {63'd0, cpu_en}, 64'd1);
        chk("pre_rst_led",    {56'd0, led},    64'h55);
        rst = 1'b1;
        #1;
        chk("async_rst_cpu_en",   {63'd0, cpu_en},   64'd0);
        chk("async_rst_count",    {59'd0, count},    64'd0);
        chk("async_rst_led",      {56'd0, led},      64'd0);
        chk("async_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        mode = 2'b00;
        e0 = en_seen;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_no_resume", 64'(en_seen - e0), 64'd0);
        chk("post_rst_count",     {59'd0, count},    64'd0);

`ifdef DBG_TRACE_WRAP_EN
        // ---------------- FREE with overwrite ----------------
        e0 = en_seen;
        mode = 2'b11; tr_inst = 32'd1;
        tick();
        for (int s = 0; s < 20; s++) begin
            tr_inst = 32'(s + 1);
            if (s == 19) mode = 2'b00;
            tick();
        end
        chk("wrap_en_cycles", 64'(en_seen - e0), 64'd20);
        chk("wrap_count",     {59'd0, count},    64'd16);
        chk("wrap_full",      {63'd0, full},     64'd1);
        chk("wrap_overflow",  {63'd0, overflow}, 64'd1);
        chk("wrap_head_inst", {32'd0, rd_inst},  64'd5);
        mode = 2'b01; tr_inst = 32'h99; step = 1'b1;
        tick();
        step = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("wrap_pushpop_count", {59'd0, count},    64'd16);
        chk("wrap_pushpop_head",  {32'd0, rd_inst},  64'd6);
        chk("wrap_sticky_ovf",    {63'd0, overflow}, 64'd1);
`else
        // ---------------- FREE with stall when full ----------------
        e0 = en_seen;
        mode = 2'b11; tr_inst = 32'd1;
        tick();
        for (int s = 0; s < 20; s++) begin
            tr_inst = 32'(s + 1);
            tick();
        end
        chk("stall_en_cycles", 64'(en_seen - e0), 64'd16);
        chk("stall_full",      {63'd0, full},     64'd1);
        chk("stall_count",     {59'd0, count},    64'd16);
        chk("stall_cpu_en",    {63'd0, cpu_en},   64'd0);
        chk("stall_overflow",  {63'd0, overflow}, 64'd0);
        chk("stall_head_inst", {32'd0, rd_inst},  64'd1);
        e0 = en_seen;
        tr_inst = 32'h50;
        pop_one();
        tick(); tick(); tick();
        chk("stall_one_more",  64'(en_seen - e0), 64'd1);
        chk("stall_refull",    {63'd0, full},     64'd1);
        chk("stall_pop_head",  {32'd0, rd_inst},  64'd2);
        mode = 2'b00;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
